// File: rtl/hazard_lock_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_lock_ctrl
//
// Pipeline sequencing controller for the IF_ID and DEC_ALU pipeline
// registers. It decides each cycle whether the front end advances, whether
// DEC_ALU loads a bubble, and whether IF_ID is flushed. Three stall sources
// are handled, highest priority first:
//   1. taken branch / jump in the ALU stage  -> flush IF_ID, bubble DEC_ALU
//   2. multi-cycle ALU op                    -> hold IF_ID and DEC_ALU
//   3. load-use hazard                       -> hold IF_ID, bubble DEC_ALU
//
// Configuration:
//   HAZARD_PERF_CNT_EN  when defined, stallCount counts stalled cycles
//                       (saturating at 16'hFFFF); when undefined it is
//                       tied to zero and its register is not built.
//
// Parameters:
//   OPW           opcode width
//   RAW           register address width
//   MC_CYCLES     stall cycles per multi-cycle ALU op (1..15)
//   LOAD_BUBBLES  bubbles inserted per load-use hazard (1..3)
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous reset, active-low
//   opCodeEx       opcode held in the ALU stage
//   exValid        ALU stage holds a valid, non-bubble instruction
//   rdAddrEx       ALU-stage destination register
//   writeEnableEx  ALU-stage instruction writes rd
//   mcReqEx        ALU-stage instruction is a multi-cycle op
//   branchTaken    ALU stage resolved a taken branch or jump this cycle
//   rs1AddrDec     decode-stage source register 1
//   rs2AddrDec     decode-stage source register 2
//   useRs1Dec      decode stage reads rs1
//   useRs2Dec      decode stage reads rs2
//   advanceIF      PC and IF_ID load enable
//   advanceDec     DEC_ALU load enable (locker)
//   bubbleDec      DEC_ALU loads a NOP
//   flushIFID      IF_ID loads a NOP
//   state          FSM state: 0 = RUN, 1 = LOAD_STALL, 2 = MC_WAIT
//   stallCount     count of stalled cycles
//
// All control outputs are Mealy: they depend on the registered state and
// counter plus the current inputs, and take effect at the next clk edge.
// ---------------------------------------------------------------------------
module hazard_lock_ctrl #(
    parameter int OPW          = 7,
    parameter int RAW          = 5,
    parameter int MC_CYCLES    = 4,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opCodeEx,
    input  logic           exValid,
    input  logic [RAW-1:0] rdAddrEx,
    input  logic           writeEnableEx,
    input  logic           mcReqEx,
    input  logic           branchTaken,
    input  logic [RAW-1:0] rs1AddrDec,
    input  logic [RAW-1:0] rs2AddrDec,
    input  logic           useRs1Dec,
    input  logic           useRs2Dec,
    output logic           advanceIF,
    output logic           advanceDec,
    output logic           bubbleDec,
    output logic           flushIFID,
    output logic [1:0]     state,
    output logic [15:0]    stallCount
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MC_WAIT    = 2'd2
    } state_t;

    localparam logic [OPW-1:0] LOAD_OP = OPW'(7'b0000011);

    // The first stall cycle of either kind happens while still in RUN, so
    // the counters are preloaded with one less than the remaining cycles.
    localparam logic [3:0] MC_INIT = 4'(MC_CYCLES - 1);
    localparam logic [3:0] LB_INIT = 4'((LOAD_BUBBLES > 1) ? (LOAD_BUBBLES - 2) : 0);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;

    // -----------------------------------------------------------------------
    // Load-use detection: a valid load in the ALU stage writing a non-zero
    // register that the decode stage is about to read.
    // -----------------------------------------------------------------------
    always_comb begin
        load_use = exValid && (opCodeEx == LOAD_OP) && writeEnableEx &&
                   (rdAddrEx != '0) &&
                   ((useRs1Dec && (rs1AddrDec == rdAddrEx)) ||
                    (useRs2Dec && (rs2AddrDec == rdAddrEx)));
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and Mealy outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can leave a value held (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        advanceIF  = 1'b1;
        advanceDec = 1'b1;
        bubbleDec  = 1'b0;
        flushIFID  = 1'b0;

        if (!reset) begin
            // Fill the pipe with NOPs while reset is held.
            advanceIF  = 1'b0;
            advanceDec = 1'b1;
            bubbleDec  = 1'b1;
            flushIFID  = 1'b1;
            state_d    = RUN;
            cnt_d      = 4'd0;
        end else if (branchTaken) begin
            // Wrong-path instructions in IF_ID and decode are squashed; any
            // stall in progress belongs to a squashed or completed sequence.
            advanceIF  = 1'b1;
            advanceDec = 1'b1;
            bubbleDec  = 1'b1;
            flushIFID  = 1'b1;
            state_d    = RUN;
            cnt_d      = 4'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mcReqEx && exValid) begin
                        advanceIF  = 1'b0;
                        advanceDec = 1'b0;
                        state_d    = MC_WAIT;
                        cnt_d      = MC_INIT;
                    end else if (load_use) begin
                        advanceIF  = 1'b0;
                        advanceDec = 1'b1;
                        bubbleDec  = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = LB_INIT;
                        end
                    end
                end

                LOAD_STALL: begin
                    // The hazard is not re-checked here: the bubble count
                    // was fixed when the hazard was first seen.
                    advanceIF  = 1'b0;
                    advanceDec = 1'b1;
                    bubbleDec  = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end

                MC_WAIT: begin
                    // mcReqEx stays high while the op is held, so it is
                    // ignored here; cnt alone decides the release cycle.
                    if (cnt_q != 4'd0) begin
                        advanceIF  = 1'b0;
                        advanceDec = 1'b0;
                        cnt_d      = cnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign state = state_q;

    // -----------------------------------------------------------------------
    // Stall performance counter
    // -----------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (!advanceIF && !branchTaken && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stallCount = stall_cnt_q;
`else
    assign stallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_lock_ctrl
//
// Two instances share one set of inputs:
//   dut_a : MC_CYCLES=4, LOAD_BUBBLES=1
//   dut_b : MC_CYCLES=1, LOAD_BUBBLES=3
// The stimulus process drives inputs just after each rising edge and pushes
// the hand-computed expected outputs for that cycle (tagged with which
// instance they apply to). The monitor pops one entry per falling edge and
// compares it with the selected instance's outputs.
// ---------------------------------------------------------------------------
module tb_hazard_lock_ctrl;

    logic        clk;
    logic        reset;
    logic [6:0]  opCodeEx;
    logic        exValid;
    logic [4:0]  rdAddrEx;
    logic        writeEnableEx;
    logic        mcReqEx;
    logic        branchTaken;
    logic [4:0]  rs1AddrDec;
    logic [4:0]  rs2AddrDec;
    logic        useRs1Dec;
    logic        useRs2Dec;

    logic        a_advanceIF, a_advanceDec, a_bubbleDec, a_flushIFID;
    logic [1:0]  a_state;
    logic [15:0] a_stallCount;
    logic        b_advanceIF, b_advanceDec, b_bubbleDec, b_flushIFID;
    logic [1:0]  b_state;
    logic [15:0] b_stallCount;

    hazard_lock_ctrl #(.OPW(7), .RAW(5), .MC_CYCLES(4), .LOAD_BUBBLES(1)) dut_a (
        .clk(clk), .reset(reset),
        .opCodeEx(opCodeEx), .exValid(exValid), .rdAddrEx(rdAddrEx),
        .writeEnableEx(writeEnableEx), .mcReqEx(mcReqEx), .branchTaken(branchTaken),
        .rs1AddrDec(rs1AddrDec), .rs2AddrDec(rs2AddrDec),
        .useRs1Dec(useRs1Dec), .useRs2Dec(useRs2Dec),
        .advanceIF(a_advanceIF), .advanceDec(a_advanceDec), .bubbleDec(a_bubbleDec),
        .flushIFID(a_flushIFID), .state(a_state), .stallCount(a_stallCount)
    );

    hazard_lock_ctrl #(.OPW(7), .RAW(5), .MC_CYCLES(1), .LOAD_BUBBLES(3)) dut_b (
        .clk(clk), .reset(reset),
        .opCodeEx(opCodeEx), .exValid(exValid), .rdAddrEx(rdAddrEx),
        .writeEnableEx(writeEnableEx), .mcReqEx(mcReqEx), .branchTaken(branchTaken),
        .rs1AddrDec(rs1AddrDec), .rs2AddrDec(rs2AddrDec),
        .useRs1Dec(useRs1Dec), .useRs2Dec(useRs2Dec),
        .advanceIF(b_advanceIF), .advanceDec(b_advanceDec), .bubbleDec(b_bubbleDec),
        .flushIFID(b_flushIFID), .state(b_state), .stallCount(b_stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        int          tag;
        logic        eif;
        logic        edec;
        logic        ebub;
        logic        efl;
        logic [1:0]  est;
        logic [15:0] esc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    // Expected stall count: real only when the performance counter is built.
    function automatic logic [15:0] pc(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return n[15:0];
`else
        return 16'h0000 & n[15:0];
`endif
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, tag, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on falling edges.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.sel) begin
                check("a_advanceIF",  e.tag, 32'(a_advanceIF),  32'(e.eif));
                check("a_advanceDec", e.tag, 32'(a_advanceDec), 32'(e.edec));
                check("a_bubbleDec",  e.tag, 32'(a_bubbleDec),  32'(e.ebub));
                check("a_flushIFID",  e.tag, 32'(a_flushIFID),  32'(e.efl));
                check("a_state",      e.tag, 32'(a_state),      32'(e.est));
                check("a_stallCount", e.tag, 32'(a_stallCount), 32'(e.esc));
            end else begin
                check("b_advanceIF",  e.tag, 32'(b_advanceIF),  32'(e.eif));
                check("b_advanceDec", e.tag, 32'(b_advanceDec), 32'(e.edec));
                check("b_bubbleDec",  e.tag, 32'(b_bubbleDec),  32'(e.ebub));
                check("b_flushIFID",  e.tag, 32'(b_flushIFID),  32'(e.efl));
                check("b_state",      e.tag, 32'(b_state),      32'(e.est));
                check("b_stallCount", e.tag, 32'(b_stallCount), 32'(e.esc));
            end
        end
    end

    task automatic idle();
        opCodeEx      = 7'h00;
        exValid       = 1'b0;
        rdAddrEx      = 5'd0;
        writeEnableEx = 1'b0;
        mcReqEx       = 1'b0;
        branchTaken   = 1'b0;
        rs1AddrDec    = 5'd0;
        rs2AddrDec    = 5'd0;
        useRs1Dec     = 1'b0;
        useRs2Dec     = 1'b0;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2);
        idle();
        opCodeEx      = 7'h03;
        exValid       = 1'b1;
        writeEnableEx = 1'b1;
        rdAddrEx      = rd;
        rs1AddrDec    = r1;
        useRs1Dec     = u1;
        rs2AddrDec    = r2;
        useRs2Dec     = u2;
    endtask

    task automatic mc();
        idle();
        opCodeEx      = 7'h33;
        exValid       = 1'b1;
        writeEnableEx = 1'b1;
        rdAddrEx      = 5'd9;
        mcReqEx       = 1'b1;
    endtask

    // Push the expectation for the inputs currently applied, then move to
    // just after the next rising edge.
    task automatic cyc(input bit sel, input logic eif, input logic edec,
                       input logic ebub, input logic efl, input logic [1:0] est,
                       input int esc);
        exp_t e;
        e.sel  = sel;
        e.tag  = step;
        e.eif  = eif;
        e.edec = edec;
        e.ebub = ebub;
        e.efl  = efl;
        e.est  = est;
        e.esc  = pc(esc);
        step++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // ---------------- dut_a: MC_CYCLES=4, LOAD_BUBBLES=1 ----------------
        // Reset held for three cycles: NOP fill.
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0);
        reset = 1'b1;
        cyc(0, 1, 1, 0, 0, 0, 0);

        // Load-use through rs2: one bubble, stays in RUN.
        ld(5, 0, 0, 5, 1);   cyc(0, 0, 1, 1, 0, 0, 0);
        idle();              cyc(0, 1, 1, 0, 0, 0, 1);
        // Load to x0: no hazard.
        ld(0, 0, 0, 0, 1);   cyc(0, 1, 1, 0, 0, 0, 1);
        // Matching rs1 but not used, rs2 used but different: no hazard.
        ld(5, 5, 0, 7, 1);   cyc(0, 1, 1, 0, 0, 0, 1);
        // Load-use through rs1.
        ld(5, 5, 1, 0, 0);   cyc(0, 0, 1, 1, 0, 0, 1);
        // Not a load opcode: no hazard.
        ld(5, 5, 1, 0, 0); opCodeEx = 7'h33;     cyc(0, 1, 1, 0, 0, 0, 2);
        // Load not valid: no hazard.
        ld(5, 5, 1, 0, 0); exValid = 1'b0;       cyc(0, 1, 1, 0, 0, 0, 2);
        // Load without write enable: no hazard.
        ld(5, 5, 1, 0, 0); writeEnableEx = 1'b0; cyc(0, 1, 1, 0, 0, 0, 2);

        // Multi-cycle op: 4 held cycles, MC_WAIT visible for 4 cycles
        // (the last one is the release), mcReqEx still high on release.
        mc();
        cyc(0, 0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 2, 3);
        cyc(0, 0, 0, 0, 0, 2, 4);
        cyc(0, 0, 0, 0, 0, 2, 5);
        cyc(0, 1, 1, 0, 0, 2, 6);
        idle();              cyc(0, 1, 1, 0, 0, 0, 6);

        // Branch and load-use together: branch wins, nothing counted.
        ld(5, 5, 1, 0, 0); branchTaken = 1'b1;   cyc(0, 1, 1, 1, 1, 0, 6);
        idle();              cyc(0, 1, 1, 0, 0, 0, 6);
        // Branch and multi-cycle request together.
        mc(); branchTaken = 1'b1;                cyc(0, 1, 1, 1, 1, 0, 6);
        idle();              cyc(0, 1, 1, 0, 0, 0, 6);

        // Branch aborts MC_WAIT.
        mc();
        cyc(0, 0, 0, 0, 0, 0, 6);
        cyc(0, 0, 0, 0, 0, 2, 7);
        branchTaken = 1'b1;  cyc(0, 1, 1, 1, 1, 2, 8);
        idle();              cyc(0, 1, 1, 0, 0, 0, 8);

        // Reset asserted mid-stall: immediate return to RUN, counter cleared.
        mc();
        cyc(0, 0, 0, 0, 0, 0, 8);
        cyc(0, 0, 0, 0, 0, 2, 9);
        reset = 1'b0; idle(); cyc(0, 0, 1, 1, 1, 0, 0);
        reset = 1'b1;         cyc(0, 1, 1, 0, 0, 0, 0);

        // Saturation: 65540 consecutive load-use stall cycles.
        ld(5, 0, 0, 5, 1);
        repeat (65540) @(posedge clk);
        #1;
        idle();              cyc(0, 1, 1, 0, 0, 0, 65535);
        ld(5, 0, 0, 5, 1);   cyc(0, 0, 1, 1, 0, 0, 65535);
        idle();              cyc(0, 1, 1, 0, 0, 0, 65535);

        // ---------------- dut_b: MC_CYCLES=1, LOAD_BUBBLES=3 ----------------
        reset = 1'b0; idle(); cyc(1, 0, 1, 1, 1, 0, 0);
        reset = 1'b1;         cyc(1, 1, 1, 0, 0, 0, 0);

        // Three bubbles; LOAD_STALL does not re-check the (now absent) hazard.
        ld(5, 0, 0, 5, 1);   cyc(1, 0, 1, 1, 0, 0, 0);
        idle();              cyc(1, 0, 1, 1, 0, 1, 1);
        cyc(1, 0, 1, 1, 0, 1, 2);
        cyc(1, 1, 1, 0, 0, 0, 3);

        // Single-cycle multi-cycle stall.
        mc();
        cyc(1, 0, 0, 0, 0, 0, 3);
        cyc(1, 1, 1, 0, 0, 2, 4);
        idle();              cyc(1, 1, 1, 0, 0, 0, 4);

        // Branch during LOAD_STALL returns to RUN.
        ld(5, 5, 1, 0, 0);   cyc(1, 0, 1, 1, 0, 0, 4);
        idle(); branchTaken = 1'b1; cyc(1, 1, 1, 1, 1, 1, 5);
        idle();              cyc(1, 1, 1, 0, 0, 0, 5);

        // Every expectation must have been consumed by the monitor.
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
